// File: rtl/demux_1to2_if.sv
// demux_1to2 stream bundle: one producer channel in, two consumer channels out.
// The producer drives master; the demultiplexer sits on slave.
interface demux_1to2_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] hyrja;
  logic             select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dalja0;
  logic [WIDTH-1:0] dalja1;
  logic             valid0;
  logic             valid1;
  logic             ready0;
  logic             ready1;

  modport master (
    output hyrja, select, in_valid,
    output ready0, ready1,
    input  in_ready,
    input  dalja0, dalja1,
    input  valid0, valid1
  );

  modport slave (
    input  hyrja, select, in_valid,
    input  ready0, ready1,
    output in_ready,
    output dalja0, dalja1,
    output valid0, valid1
  );
endinterface

// File: rtl/demux_1to2.sv
// Registered 1-to-2 stream demultiplexer, one holding register.
// Define DEMUX_COUNT_EN to add per-channel transfer counters.
module demux_1to2 #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic Clock,
  input  logic Reset,
  demux_1to2_if.slave bus
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             w_full;
  logic             w_sel_rdy;
  logic             w_otx;
  logic             w_in_rdy;
  logic             w_itx;
  logic             w_load;

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("demux_1to2: WIDTH and CNT_W must be >= 1");
  end

  assign w_full    = (r_state == FULL);
  assign w_sel_rdy = r_sel ? bus.ready1 : bus.ready0;
  assign w_otx     = w_full && w_sel_rdy;
  assign w_in_rdy  = !w_full || w_sel_rdy;
  assign w_itx     = bus.in_valid && w_in_rdy;

  assign bus.in_ready = w_in_rdy;
  assign bus.valid0   = w_full && !r_sel;
  assign bus.valid1   = w_full && r_sel;
  assign bus.dalja0   = r_data;
  assign bus.dalja1   = r_data;

  // State register; reset wins over any transfer.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  // Next state and register-load decision.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_itx) begin
          w_next = FULL;
          w_load = 1'b1;
        end
      end
      FULL: begin
        if (w_itx) begin
          w_load = 1'b1;
        end else if (w_otx) begin
          w_next = EMPTY;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  // Holding register: word and its destination.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_data <= '0;
      r_sel  <= 1'b0;
    end else if (w_load) begin
      r_data <= bus.hyrja;
      r_sel  <= bus.select;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Per-channel output transfer counters, wrapping.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_otx) begin
      if (r_sel) r_cnt1 <= r_cnt1 + CNT_W'(1);
      else       r_cnt0 <= r_cnt0 + CNT_W'(1);
    end
  end

  assign count0 = r_cnt0;
  assign count1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Randomised and directed bench for demux_1to2 against a queue model.
// Define DEMUX_COUNT_EN to also check the counters (CNT_W = 4).
module tb_demux_1to2;
  localparam int WIDTH = 24;
`ifdef DEMUX_COUNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  demux_1to2_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;
`endif

  demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
`ifdef DEMUX_COUNT_EN
    ,
    .count0(count0),
    .count1(count1)
`endif
  );

  always #5 Clock = ~Clock;

  // Model: words accepted but not yet delivered, {sel, data}.
  logic [WIDTH:0]   mq[$];
  int               m_cnt0 = 0;
  int               m_cnt1 = 0;
  // Log of delivered words.
  logic [WIDTH-1:0] log_d[$];
  int               log_ch[$];
  int               log_cyc[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Compare process: check outputs, then advance the model across the next edge.
  always @(negedge Clock) begin
    logic e_v0, e_v1, e_rdy, otx, itx, fsel;
    logic [WIDTH-1:0] fdat;
    fsel = 1'b0;
    fdat = '0;
    if (mq.size() != 0) begin
      fsel = mq[0][WIDTH];
      fdat = mq[0][WIDTH-1:0];
    end
    e_v0  = (mq.size() != 0) && !fsel;
    e_v1  = (mq.size() != 0) && fsel;
    e_rdy = (mq.size() == 0) || (fsel ? bus.ready1 : bus.ready0);
    chk("valid0", bus.valid0, e_v0);
    chk("valid1", bus.valid1, e_v1);
    chk("in_ready", bus.in_ready, e_rdy);
    if (e_v0) chk("dalja0", bus.dalja0, fdat);
    if (e_v1) chk("dalja1", bus.dalja1, fdat);
`ifdef DEMUX_COUNT_EN
    chk("count0", count0, m_cnt0 % (1 << CNT_W));
    chk("count1", count1, m_cnt1 % (1 << CNT_W));
`endif
    if (Reset) begin
      mq.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      otx = (mq.size() != 0) && (fsel ? bus.ready1 : bus.ready0);
      itx = bus.in_valid && e_rdy;
      if (otx) begin
        log_d.push_back(fdat);
        log_ch.push_back(int'(fsel));
        log_cyc.push_back(cyc);
        if (fsel) m_cnt1++;
        else      m_cnt0++;
        void'(mq.pop_front());
      end
      if (itx) mq.push_back({bus.select, bus.hyrja});
    end
  end

  task automatic drive(input logic v, input logic s,
                       input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    @(posedge Clock);
    #1;
    bus.in_valid = v;
    bus.select   = s;
    bus.hyrja    = d;
    bus.ready0   = r0;
    bus.ready1   = r1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b1;
    bus.select   = 1'b0;
    bus.hyrja    = 24'h111111;
    bus.ready0   = 1'b0;
    bus.ready1   = 1'b0;
    Reset        = 1'b1;

    // Reset held two cycles with in_valid high.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_valid0", bus.valid0, 0);
    chk("rst_valid1", bus.valid1, 0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef DEMUX_COUNT_EN
    chk("rst_count0", count0, 0);
    chk("rst_count1", count1, 0);
`endif

    // Single steer to channel 1.
    drive(1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("steer_valid1", bus.valid1, 1);
    chk("steer_valid0", bus.valid0, 0);
    chk("steer_dalja1", bus.dalja1, 24'hABCDEF);
    idle(1);
    @(negedge Clock);
    chk("steer_done", bus.valid1, 0);
`ifdef DEMUX_COUNT_EN
    chk("steer_count1", count1, 1);
`endif

    // Back-pressure on channel 0; ready1 high must be ignored.
    base = log_d.size();
    drive(1'b1, 1'b0, 24'h000123, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 24'h000456, 1'b0, 1'b1);
      @(negedge Clock);
      chk("bp_valid0", bus.valid0, 1);
      chk("bp_dalja0", bus.dalja0, 24'h000123);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    drive(1'b1, 1'b0, 24'h000456, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("bp_n", log_d.size() - base, 2);
    if (log_d.size() - base == 2) begin
      chk("bp_w0", log_d[base], 24'h000123);
      chk("bp_w1", log_d[base+1], 24'h000456);
    end

    // Streaming alternation of words 1..8.
    base = log_d.size();
    for (int i = 1; i <= 8; i++)
      drive(1'b1, (i % 2 == 0), WIDTH'(i), 1'b1, 1'b1);
    idle(3);
    chk("str_n", log_d.size() - base, 8);
    if (log_d.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("str_data", log_d[base+i], i + 1);
        chk("str_ch", log_ch[base+i], (i % 2 == 0) ? 0 : 1);
        if (i > 0)
          chk("str_gap", log_cyc[base+i] - log_cyc[base+i-1], 1);
      end
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    idle(3);

    // Mid-transfer reset discards the held word.
    base = log_d.size();
    drive(1'b1, 1'b0, 24'h5A5A5A, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge Clock);
    chk("mr_full", bus.valid0, 1);
    Reset = 1'b1;
    @(negedge Clock);
    chk("mr_valid0", bus.valid0, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    Reset = 1'b0;
    idle(3);
    chk("mr_dropped", log_d.size() - base, 0);

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 17 channel-0 transfers.
    for (int i = 0; i < 17; i++)
      drive(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0);
    idle(2);
    @(negedge Clock);
    chk("wrap_count0", count0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1to2.md
# demux_1to2

Registered 1-to-2 stream demultiplexer for the 24-bit datapath. It accepts one word per handshake on a single input channel and steers it to exactly one of two output channels, chosen by a per-word select bit. It is the fan-out counterpart of the 2-to-1 selectors on the datapath, and sits wherever one producer (for example, the ALU result bus) must feed two consumers (register-file write port or memory write port).

## Interface
- `WIDTH`, 24, data word width in bits.
- `CNT_W`, 16, width of per-channel transfer counters (used only when `DEMUX_COUNT_EN` is defined).
- `Clock`  in  1  rising-edge clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `hyrja`  in  WIDTH  input data word.
- `select`  in  1  destination of the input word: 0 → channel 0, 1 → channel 1.
- `in_valid`  in  1  input word and select are valid.
- `in_ready`  out  1  block can accept the input this cycle.
- `dalja0`, `dalja1`  out  WIDTH  output data, channels 0 and 1.
- `valid0`, `valid1`  out  1  output word valid on channel 0 or 1.
- `ready0`, `ready1`  in  1  consumer 0 or 1 accepts the word.
- `count0`, `count1`  out  CNT_W  accepted-transfer counters (present only with `DEMUX_COUNT_EN`).

## Operation
- The block has one holding register (`data_q`, `sel_q`) and a two-state FSM: EMPTY and FULL.
- Input transfer occurs when `in_valid && in_ready`. Output transfer on channel k occurs when `valid_k && ready_k`.
- `valid0 = FULL && !sel_q`. `valid1 = FULL && sel_q`. At most one valid is high in any cycle.
- `dalja0` and `dalja1` both drive `data_q`. Their value is only meaningful while the matching valid is high.
- `in_ready = EMPTY || (FULL && ready_of_selected_channel)`. This gives one-word-per-cycle throughput when the consumer keeps accepting.
- FSM transitions:
  - EMPTY with input transfer → FULL; load `data_q`/`sel_q`.
  - FULL with output transfer and no input transfer → EMPTY.
  - FULL with both output and input transfer → stays FULL; reload the register with the new word.
  - FULL with no output transfer → hold. Data and select stay stable, and `in_ready = 0`.
- The ready of the non-selected channel is ignored.
- `select` is sampled only on an input transfer. Changing it while the block is FULL does not affect the held word.
- Words are never dropped, duplicated or reordered.

## Timing
- Reset values: FSM = EMPTY, `data_q` = 0, `sel_q` = 0, `valid0` = `valid1` = 0, `in_ready` = 1 from the first cycle after reset, counters = 0.
- Latency: a word accepted at edge N is valid on its output from edge N through edge N+1 onward, i.e. one cycle.
- Throughput: one word per cycle when the selected ready is held high.
- Once valid_k is asserted, it stays asserted with stable data until the channel-k transfer occurs.
- Combinational paths: `ready0`/`ready1` → `in_ready` only. There is no path from input to output valid or data.
- Reset asserted mid-transfer: the held word is discarded and all outputs take their reset values at the next edge. Reset has priority over every transfer.

## Configuration
- `DEMUX_COUNT_EN`:
  - Defined: `count0`/`count1` ports and counters exist. Each counter increments by 1 on every output transfer on its channel and wraps from 2^CNT_W−1 to 0. Counters reset to 0.
  - Undefined: the ports and counter logic are absent. Datapath behaviour is identical in both builds.

## Test plan
- Reset: hold `Reset` for 2 cycles with `in_valid` = 1 → `valid0` = `valid1` = 0; after release, `in_ready` = 1, counters = 0.
- Single steer: send 0xABCDEF with `select` = 1 and `ready1` = 1 → next cycle `valid1` = 1, `dalja1` = 0xABCDEF, `valid0` = 0; `count1` = 1 after the transfer.
- Back-pressure: send 0x000123 with `select` = 0 and `ready0` = 0 for 5 cycles → `valid0` and `dalja0` stay stable and `in_ready` = 0; a second word offered meanwhile is not accepted. Raise `ready0` → both words arrive in order.
- Streaming alternation: 8 words 1..8 with select 0,1,0,1,…, both readies high → one word per cycle, odd words on channel 0 and even words on channel 1, no gaps; `count0` = `count1` = 4.
- Ignored ready: hold a channel-0 word with `ready0` = 0 and `ready1` = 1 → no transfer occurs and `in_ready` = 0.
- Wrap and mid-reset: with `CNT_W` = 4, make 17 channel-0 transfers → `count0` = 1. Assert `Reset` while FULL → `valid0` = 0 at the next edge, and the held word never appears.
